// File: rtl/spi_frame_slave_if.sv
// ---------------------------------------------------------------------------
// spi_frame_slave_if
//   Register-side bus between the SPI frame decoder and the register wrapper.
//
//   reg_addr [6:0]  address latched from the command byte
//   rw_out          1 = read frame (host reads from target)
//   addr_dv         command decoded and frame still open
//   rx_d     [7:0]  last received write-data byte
//   rxdv            one-cycle strobe, rx_d valid
//   tx_d     [7:0]  read data returned by the wrapper
//   tx_en           tx_d is valid (address maps to a readable register)
//   tx_load         one-cycle strobe, tx_d captured (pop for FIFO registers)
//
//   Modport "master" is the frame decoder, which originates the address and
//   write data; modport "slave" is the register wrapper answering it.
// ---------------------------------------------------------------------------
interface spi_frame_slave_if;
    logic [6:0] reg_addr;
    logic       rw_out;
    logic       addr_dv;
    logic [7:0] rx_d;
    logic       rxdv;
    logic [7:0] tx_d;
    logic       tx_en;
    logic       tx_load;

    modport master (
        output reg_addr, rw_out, addr_dv, rx_d, rxdv, tx_load,
        input  tx_d, tx_en
    );

    modport slave (
        input  reg_addr, rw_out, addr_dv, rx_d, rxdv, tx_load,
        output tx_d, tx_en
    );
endinterface

// File: rtl/spi_frame_slave.sv
// ---------------------------------------------------------------------------
// spi_frame_slave
//   SPI mode-0 target front end. The SPI pins are oversampled in the clk
//   domain; each chip-select frame is decoded into a command byte
//   (R/W flag + 7-bit address) followed by any number of data bytes.
//
//   clk          system clock, at least 8x SCK
//   reset_n      synchronous, active-low reset
//   sck/cs_n/mosi  asynchronous SPI pins
//   miso         SPI data out, MSB first, 0 when not selected
//   frame_err    one-cycle strobe: cs_n released in the middle of a byte
//   byte_cnt     data bytes completed in the current frame (saturating)
//   bus          register-side interface (master modport)
// ---------------------------------------------------------------------------
module spi_frame_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      sck,
    input  logic                      cs_n,
    input  logic                      mosi,
    output logic                      miso,
    output logic                      frame_err,
    output logic [7:0]                byte_cnt,
    spi_frame_slave_if.master         bus
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] sck_sync_reg, cs_sync_reg, mosi_sync_reg;
    logic       sck_hist_reg, cs_hist_reg;

    logic [7:0] shift_in_reg, shift_out_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] byte_cnt_reg;
    logic [6:0] reg_addr_reg;
    logic       rw_reg, addr_dv_reg, rxdv_reg, frame_err_reg;
    logic [7:0] rx_d_reg;
    logic       load_req_reg, tx_load_reg;

    logic       sck_s, cs_s, mosi_s;
    logic       sck_rise, sck_fall, cs_rise, cs_fall, byte_end;
    logic [7:0] byte_in;

    assign sck_s  = sck_sync_reg[SYNC_STAGES-1];
    assign cs_s   = cs_sync_reg[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

    // SCK edges only count while the synchronized select is active.
    assign sck_rise = sck_s & ~sck_hist_reg & ~cs_s;
    assign sck_fall = ~sck_s & sck_hist_reg & ~cs_s;
    assign cs_rise  = cs_s & ~cs_hist_reg;
    assign cs_fall  = ~cs_s & cs_hist_reg;
    assign byte_in  = {shift_in_reg[6:0], mosi_s};
    assign byte_end = sck_rise && (bit_cnt_reg == 3'd7);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cs_fall) state_next = CMD;
            CMD:     if (cs_rise) state_next = IDLE;
                     else if (byte_end) state_next = DATA;
            DATA:    if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            // The select chain clears to "selected" so that a reset taken in
            // the middle of a frame does not see a fresh cs_n fall: the rest of
            // that frame is ignored until cs_n goes high and low again.
            sck_sync_reg  <= '0;
            cs_sync_reg   <= '0;
            mosi_sync_reg <= '0;
            sck_hist_reg  <= 1'b0;
            cs_hist_reg   <= 1'b0;
            shift_in_reg  <= 8'h00;
            shift_out_reg <= 8'h00;
            bit_cnt_reg   <= 3'd0;
            byte_cnt_reg  <= 8'h00;
            reg_addr_reg  <= 7'h00;
            rw_reg        <= 1'b0;
            addr_dv_reg   <= 1'b0;
            rx_d_reg      <= 8'h00;
            rxdv_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            load_req_reg  <= 1'b0;
            tx_load_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
            cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
            sck_hist_reg  <= sck_s;
            cs_hist_reg   <= cs_s;

            rxdv_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            load_req_reg  <= 1'b0;
            // A byte boundary requests read data one cycle later, which gives
            // the wrapper a cycle after addr_dv to present tx_d. A request is
            // dropped if the frame closes before it is served, so a FIFO is
            // never popped for a byte the host will not clock out.
            tx_load_reg   <= load_req_reg && (state_reg != IDLE) && !cs_rise;

            if (state_reg == IDLE) begin
                if (cs_fall) begin
                    bit_cnt_reg   <= 3'd0;
                    byte_cnt_reg  <= 8'h00;
                    shift_in_reg  <= 8'h00;
                    shift_out_reg <= 8'h00;
                end
            end else if (cs_rise) begin
                // Frame close wins over a simultaneous SCK rise.
                addr_dv_reg   <= 1'b0;
                shift_in_reg  <= 8'h00;
                bit_cnt_reg   <= 3'd0;
                frame_err_reg <= (bit_cnt_reg != 3'd0);
            end else begin
                if (sck_rise) begin
                    shift_in_reg <= byte_in;
                    bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                end
                if (byte_end) begin
                    if (state_reg == CMD) begin
                        rw_reg       <= byte_in[7];
                        reg_addr_reg <= byte_in[6:0];
                        addr_dv_reg  <= 1'b1;
                        load_req_reg <= byte_in[7];
                    end else begin
                        if (byte_cnt_reg != 8'hFF)
                            byte_cnt_reg <= byte_cnt_reg + 8'd1;
                        if (rw_reg) begin
                            load_req_reg <= 1'b1;
                        end else begin
                            rx_d_reg <= byte_in;
                            rxdv_reg <= 1'b1;
                        end
                    end
                end
                // The fall right after a boundary sees bit_cnt == 0 and leaves
                // the freshly loaded MSB on miso for the host's next rise.
                if (tx_load_reg)
                    shift_out_reg <= bus.tx_en ? bus.tx_d : 8'h00;
                else if (sck_fall && (bit_cnt_reg != 3'd0))
                    shift_out_reg <= {shift_out_reg[6:0], 1'b0};
            end
        end
    end

    assign miso         = (state_reg != IDLE) ? shift_out_reg[7] : 1'b0;
    assign frame_err    = frame_err_reg;
    assign byte_cnt     = byte_cnt_reg;
    assign bus.reg_addr = reg_addr_reg;
    assign bus.rw_out   = rw_reg;
    assign bus.addr_dv  = addr_dv_reg;
    assign bus.rx_d     = rx_d_reg;
    assign bus.rxdv     = rxdv_reg;
    assign bus.tx_load  = tx_load_reg;

endmodule
